adc_out_collector: RTL and testbench

ADC_OUT_COLLECTOR -- requirements
Module: adc_out_collector

---
 rtl/adc_out_pkg.sv | 12 +
 rtl/adc_out_fifo.sv | 45 ++++
 rtl/adc_out_collector.sv | 109 ++++++++++
 tb/tb_adc_out_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_out_pkg.sv
// rtl/adc_out_pkg.sv - shared defaults, lane width and state type for the ADC output collector
package adc_out_pkg;
  localparam int WAYS_DEFAULT  = 8;
  localparam int BITS_DEFAULT  = 9;
  localparam int LANE_W        = BITS_DEFAULT;
  localparam int DISCARD_CNT_W = 8;

  typedef enum logic {
    ST_DISCARD = 1'b0,
    ST_RUN     = 1'b1
  } state_t;
endpackage

// File: rtl/adc_out_fifo.sv
// rtl/adc_out_fifo.sv - frame FIFO with wrap-bit pointers; a read frees a slot for a same-cycle write
module adc_out_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_fire;
  logic             wr_fire;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && (!full || rd_fire);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/adc_out_collector.sv
// rtl/adc_out_collector.sv - discards settling frames after enable, then captures ADC frames into a FIFO
// Optional ADC_OUT_TWOS_COMP_EN inverts each lane MSB at capture (offset-binary to two's complement).
module adc_out_collector
  import adc_out_pkg::*;
#(
  parameter int WAYS    = WAYS_DEFAULT,
  parameter int BITS    = BITS_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int DISCARD = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WAYS*BITS-1:0] adcout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WAYS*BITS-1:0] out_data,
  output logic                 overflow,
  output logic [15:0]          drop_count
);
  localparam int W = WAYS * BITS;
  localparam logic [DISCARD_CNT_W-1:0] DISC_LAST =
    (DISCARD == 0) ? '0 : DISCARD_CNT_W'(DISCARD - 1);

  state_t                   state;
  logic [DISCARD_CNT_W-1:0] disc_cnt;
  logic [W-1:0]             conv;
  logic [W-1:0]             cap_data;
  logic                     cap_valid;
  logic [W-1:0]             fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     drop;

  always_comb begin
    conv = adcout;
`ifdef ADC_OUT_TWOS_COMP_EN
    for (int k = 0; k < WAYS; k++) begin
      conv[k*BITS + BITS - 1] = ~adcout[k*BITS + BITS - 1];
    end
`else
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_DISCARD;
      disc_cnt  <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else if (!enable) begin
      state     <= ST_DISCARD;
      disc_cnt  <= '0;
      cap_valid <= 1'b0;
    end else begin
      case (state)
        ST_DISCARD: begin
          cap_valid <= 1'b0;
          // With DISCARD=0 the counter is already at DISC_LAST, so RUN follows at once.
          if (disc_cnt == DISC_LAST) begin
            state    <= ST_RUN;
            disc_cnt <= '0;
          end else begin
            disc_cnt <= disc_cnt + DISCARD_CNT_W'(1);
          end
        end
        ST_RUN: begin
          cap_data  <= conv;
          cap_valid <= 1'b1;
        end
        default: begin
          state     <= ST_DISCARD;
          disc_cnt  <= '0;
          cap_valid <= 1'b0;
        end
      endcase
    end
  end

  // A full FIFO still accepts when the head is leaving on the same edge.
  assign drop = cap_valid && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  adc_out_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (cap_valid),
    .wr_data  (cap_data),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_data = fifo_empty ? '0 : fifo_head;
endmodule

// File: tb/tb_adc_out_collector.sv
// tb/tb_adc_out_collector.sv - directed bench with a queue-level reference model for adc_out_collector
module tb_adc_out_collector;
  localparam int WAYS  = 8;
  localparam int BITS  = 9;
  localparam int DEPTH = 4;
  localparam int DISC  = 4;
  localparam int W     = WAYS * BITS;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] adcout = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         overflow;
  logic [15:0]  drop_count;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  logic         pend_v = 1'b0;
  logic [W-1:0] pend_d = '0;
  int           streak = 0;
  int           m_over = 0;
  int           m_drops = 0;

  logic [W-1:0] got[$];
  int           first_seen;
  int           nvalid;
  logic [W-1:0] first_data;

  adc_out_collector #(
    .WAYS    (WAYS),
    .BITS    (BITS),
    .DEPTH   (DEPTH),
    .DISCARD (DISC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .adcout     (adcout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] mk(input int base);
    logic [W-1:0] f;
    for (int k = 0; k < WAYS; k++) f[k*BITS +: BITS] = BITS'(base + k * 37);
    return f;
  endfunction

  function automatic logic [W-1:0] lanes(input logic [BITS-1:0] l3, input logic [BITS-1:0] other);
    logic [W-1:0] f;
    for (int k = 0; k < WAYS; k++) f[k*BITS +: BITS] = (k == 3) ? l3 : other;
    return f;
  endfunction

  function automatic logic [W-1:0] conv(input logic [W-1:0] f);
    logic [W-1:0] r;
    r = f;
`ifdef ADC_OUT_TWOS_COMP_EN
    for (int k = 0; k < WAYS; k++) r[k*BITS + BITS - 1] = ~f[k*BITS + BITS - 1];
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a frame is captured once enable has been high for more than DISC
  // consecutive cycles; it lands in a DEPTH-deep queue one edge later.
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      q.delete();
      pend_v  = 1'b0;
      streak  = 0;
      m_over  = 0;
      m_drops = 0;
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (pend_v) begin
        if (q.size() < DEPTH) q.push_back(pend_d);
        else begin
          m_over = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      streak = enable ? streak + 1 : 0;
      pend_v = enable && (streak > DISC);
      pend_d = conv(adcout);
    end
  end

  initial forever begin
    @(negedge clock);
    check_int("valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) check("data", out_data, q[0]);
    check_int("overflow", int'(overflow), m_over);
    check_int("drop_count", int'(drop_count), m_drops);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) got.push_back(out_data);
      step();
    end
  endtask

  initial begin
    repeat (2) step();
    @(negedge clock);
    check_int("rst_valid", int'(out_valid), 0);
    check("rst_data", out_data, '0);
    check_int("rst_overflow", int'(overflow), 0);
    check_int("rst_drops", int'(drop_count), 0);

    // Startup latency and gapless streaming
    step();
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    first_seen = -1; nvalid = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      adcout = mk(16 + c);
      @(negedge clock);
      if (out_valid) begin
        nvalid++;
        if (first_seen < 0) begin
          first_seen = c;
          first_data = out_data;
        end
      end
    end
    check_int("first_valid_cycle", first_seen, 6);
    check("first_frame", first_data, mk(20));
    check_int("no_gaps", nvalid, 10);

    // Overflow: 10 captures into a 4-deep FIFO with the sink stalled
    step(); enable = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 14; i++) begin
      step(); enable = 1'b1; out_ready = 1'b0; adcout = mk(100 + i);
    end
    step(); enable = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check_int("ovf_flag", int'(overflow), 1);
    check_int("ovf_drops", int'(drop_count), 6);
    step(); out_ready = 1'b1;
    got.delete();
    collect(8);
    check_int("ovf_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) check($sformatf("ovf_frame%0d", k), got[k], mk(104 + k));

    // Full FIFO with a read on the same edge as a write
    for (int i = 0; i < 9; i++) begin
      step(); enable = 1'b1; out_ready = 1'b0; adcout = mk(200 + i);
    end
    step(); enable = 1'b0; out_ready = 1'b1;
    got.delete();
    collect(8);
    check_int("full_rw_drops", int'(drop_count), 6);
    check_int("full_rw_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) check($sformatf("full_rw_frame%0d", k), got[k], mk(204 + k));

    // One-cycle enable drop in RUN
    got.delete();
    for (int i = 0; i < 21; i++) begin
      step();
      enable = (i != 7); out_ready = (i >= 8); adcout = mk(300 + i);
      @(negedge clock);
      if (out_valid && out_ready) got.push_back(out_data);
    end
    check_int("redisc_count_ge4", int'(got.size() >= 4), 1);
    if (got.size() >= 4) begin
      check("redisc_f0", got[0], mk(304));
      check("redisc_f1", got[1], mk(305));
      check("redisc_f2", got[2], mk(306));
      check("redisc_f3", got[3], mk(312));
    end

    // Lane format conversion
    for (int i = 0; i < 6; i++) begin
      step(); adcout = lanes(9'h1FF, 9'h100);
    end
    @(negedge clock);
    check_int("fmt_valid", int'(out_valid), 1);
`ifdef ADC_OUT_TWOS_COMP_EN
    check("fmt_data", out_data, lanes(9'h0FF, 9'h000));
`else
    check("fmt_data", out_data, lanes(9'h1FF, 9'h100));
`endif

    // Reset with three frames buffered
    step(); enable = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 7; i++) begin
      step(); enable = 1'b1; out_ready = 1'b0; adcout = mk(400 + i);
    end
    step(); enable = 1'b0;
    repeat (2) step();
    @(negedge clock);
    check_int("prerst_valid", int'(out_valid), 1);
    check_int("prerst_depth", q.size(), 3);
    step(); reset = 1'b1;
    #1;
    check_int("midrst_valid", int'(out_valid), 0);
    check("midrst_data", out_data, '0);
    check_int("midrst_overflow", int'(overflow), 0);
    check_int("midrst_drops", int'(drop_count), 0);
    step(); reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    first_seen = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      adcout = mk(500 + c);
      @(negedge clock);
      if (out_valid && first_seen < 0) first_seen = c;
    end
    check_int("postrst_first_cycle", first_seen, DISC + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
